// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the data-memory load path: funct3 encodings,
// load sequencer state type and the legal-funct3 decode.
package rv32i_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } load_state_t;

    function automatic logic f3_illegal(input logic [2:0] f3);
        logic bad;
        case (f3)
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad = 1'b0;
            default:                             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_unit_if.sv
// Bundle of the execute request, data-memory read port and writeback response
// seen by the load unit; slave is the unit itself, master is its environment.
interface load_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_addr, req_funct3,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, mem_req_valid, mem_addr,
        output rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_funct3,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, mem_req_valid, mem_addr,
        input  rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/load_extend.sv
// Byte/halfword lane select and sign/zero extension of a little-endian read word.
// Purely combinational; feeds the registered response in load_unit.
module load_extend
    import rv32i_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        illegal
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic signed [31:0] sext_b;
    logic signed [31:0] sext_h;

    // Halfword lane uses only offset[1]; misaligned halves never reach here.
    assign lane_b = word[{offset, 3'b000} +: 8];
    assign lane_h = word[{offset[1], 4'b0000} +: 16];
    assign sext_b = lane_b;
    assign sext_h = lane_h;

    always_comb begin
        data    = '0;
        illegal = f3_illegal(funct3);
        case (funct3)
            F3_LB:   data = sext_b;
            F3_LH:   data = sext_h;
            F3_LW:   data = word;
            F3_LBU:  data = {24'h000000, lane_b};
            F3_LHU:  data = {16'h0000, lane_h};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// RV32I load sequencer: accepts one load, issues a word-aligned memory read,
// formats the returned lane and pulses the result to writeback.
module load_unit
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    load_unit_if.slave  bus
);

    load_state_t state;
    logic        req_ready_q;
    logic        mem_req_valid_q;
    logic [31:0] mem_addr_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic [31:0] ext_data;
    logic        ext_illegal;
    logic        req_bad;

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_LH, F3_LHU: mis = off[0];
            F3_LW:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

    assign req_bad = misaligned(bus.req_funct3, bus.req_addr[1:0]) |
                     f3_illegal(bus.req_funct3);

    // Formats from the raw memory word; only the RESP registers see the result.
    load_extend u_extend (
        .word    (bus.mem_rdata),
        .offset  (off_q),
        .funct3  (f3_q),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_addr_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            off_q           <= '0;
            f3_q            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        off_q       <= bus.req_addr[1:0];
                        f3_q        <= bus.req_funct3;
                        mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
                        req_ready_q <= 1'b0;
                        if (req_bad) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_data_q  <= '0;
                        end else begin
                            state           <= REQ;
                            mem_req_valid_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rsp_valid) begin
                        rsp_data_q  <= ext_data;
                        rsp_err_q   <= ext_illegal;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = req_ready_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit: expected responses are queued as loads are
// issued and checked by a monitor whenever rsp_valid pulses.
module tb_load_unit;
    import rv32i_pkg::*;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    exp_t sbq[$];

    load_unit_if bus ();

    load_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every response pulse must match the oldest queued load.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            tests++;
            assert (sbq.size() > 0) else begin
                fails++;
                $error("FAIL stray_rsp: observed rsp_valid=1 expected no response pending");
            end
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_data", bus.rsp_data, e.data);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, bus.rsp_data, 32'h0);
        check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
    endtask

    // One complete load; nready = REQ cycles with ready low, nrsp = WAIT cycles without data.
    task automatic load_op(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input int nready, input int nrsp,
                           input logic exp_err, input logic [31:0] exp_data);
        logic [31:0] waddr;
        waddr = {addr[31:2], 2'b00};
        @(negedge clk);
        check({tag, "_idle_ready"}, 32'(bus.req_ready), 32'd1);
        sbq.push_back('{err: exp_err, data: exp_data});
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_funct3 = f3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (exp_err) begin
            check({tag, "_err_pulse"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_err_no_mem"}, 32'(bus.mem_req_valid), 32'd0);
            @(negedge clk);
            check({tag, "_err_no_mem2"}, 32'(bus.mem_req_valid), 32'd0);
            check({tag, "_err_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
            return;
        end
        for (int i = 0; i <= nready; i++) begin
            check({tag, "_mem_req_valid"}, 32'(bus.mem_req_valid), 32'd1);
            check({tag, "_mem_addr"}, bus.mem_addr, waddr);
            check({tag, "_busy_ready"}, 32'(bus.req_ready), 32'd0);
            if (nready > 0) begin
                bus.req_valid     = 1'b1;
                bus.req_addr      = 32'h0000_5000;
                bus.req_funct3    = F3_LW;
                bus.mem_rsp_valid = 1'b1;
                bus.mem_rdata     = 32'hDEAD_BEEF;
            end
            bus.mem_req_ready = (i == nready);
            @(negedge clk);
        end
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        for (int i = 0; i < nrsp; i++) begin
            check({tag, "_wait_no_mem"}, 32'(bus.mem_req_valid), 32'd0);
            check({tag, "_wait_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
            check({tag, "_wait_addr"}, bus.mem_addr, waddr);
            @(negedge clk);
        end
        bus.req_valid     = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = rdata;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = $urandom;
        check({tag, "_rsp_pulse"}, 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_back_idle"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_funct3    = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Zero-wait lane/extension coverage.
        load_op("lb_3",   32'h0000_1003, F3_LB,  32'h80AA_55CC, 0, 0, 1'b0, 32'hFFFF_FF80);
        load_op("lb_1",   32'h0000_1001, F3_LB,  32'h80AA_55CC, 0, 0, 1'b0, 32'h0000_0055);
        load_op("lbu_2",  32'h0000_1002, F3_LBU, 32'h9234_ABCD, 0, 0, 1'b0, 32'h0000_0034);
        load_op("lhu_2",  32'h0000_1002, F3_LHU, 32'h9234_ABCD, 0, 0, 1'b0, 32'h0000_9234);
        load_op("lh_2",   32'h0000_1002, F3_LH,  32'h9234_ABCD, 0, 0, 1'b0, 32'hFFFF_9234);
        load_op("lw_0",   32'h0000_1000, F3_LW,  32'h9234_ABCD, 0, 0, 1'b0, 32'h9234_ABCD);
        load_op("lhu_0",  32'h0000_1000, F3_LHU, 32'h9234_ABCD, 0, 0, 1'b0, 32'h0000_ABCD);

        // Trapped loads: no memory traffic, zero data.
        load_op("lw_mis", 32'h0000_2002, F3_LW,  32'h0,        0, 0, 1'b1, 32'h0);
        load_op("lh_mis", 32'h0000_2001, F3_LH,  32'h0,        0, 0, 1'b1, 32'h0);
        load_op("f3_011", 32'h0000_2000, 3'b011, 32'h0,        0, 0, 1'b1, 32'h0);
        load_op("f3_111", 32'h0000_2004, 3'b111, 32'h0,        0, 0, 1'b1, 32'h0);

        // Stalled request and delayed response with a competing request and stray data.
        load_op("stall",  32'h0000_3000, F3_LH,  32'h0000_8001, 3, 4, 1'b0, 32'hFFFF_8001);

        // Reset while waiting for memory, then a late response lands in IDLE.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h0000_4004;
        bus.req_funct3 = F3_LW;
        @(negedge clk);
        bus.req_valid     = 1'b0;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("rstw_in_wait_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rstw_in_wait_ready", 32'(bus.req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rstw");
        @(negedge clk);
        rst_n             = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = 32'h1234_5678;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("late_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        check("late_rsp_dropped2", 32'(bus.rsp_valid), 32'd0);
        check("late_rsp_data", bus.rsp_data, 32'h0);
        check("late_idle_ready", 32'(bus.req_ready), 32'd1);

        load_op("lw_after", 32'h0000_4008, F3_LW, 32'hCAFE_F00D, 0, 1, 1'b0, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
